// File: rtl/cnn_accel_pkg.sv
// Shared types and constants for the CNN accelerator result stage.
// Holds the argmax FSM encoding, logit geometry and the margin helper.
package cnn_accel_pkg;

    localparam int NUM_CLASSES = 9;
    localparam int DATA_W      = 32;

    // Most negative logit; seeds the runner-up so any real logit can replace it.
    localparam logic [DATA_W-1:0] LOGIT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        KICK    = 3'd1,
        WAIT_UP = 3'd2,
        SCAN    = 3'd3,
        FINISH  = 3'd4,
        DONE    = 3'd5
    } argmax_state_t;

    // best - second at DATA_W+1 bits, clamped to all-ones if it does not fit.
    function automatic logic [DATA_W-1:0] sat_margin(
        input logic [DATA_W-1:0] best,
        input logic [DATA_W-1:0] second
    );
        logic [DATA_W:0] diff;
        diff = {best[DATA_W-1], best} - {second[DATA_W-1], second};
        return diff[DATA_W] ? {DATA_W{1'b1}} : diff[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/top2_tracker.sv
// Running top-1 / top-2 tracker over a stream of signed logits.
// Strict compares keep the lowest index on ties.
module top2_tracker
    import cnn_accel_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear_i,
    input  logic              update_i,
    input  logic              first_i,
    input  logic [DATA_W-1:0] logit_i,
    input  logic [ADDR_W-1:0] idx_i,
    output logic [DATA_W-1:0] best_o,
    output logic [DATA_W-1:0] second_o,
    output logic [ADDR_W-1:0] best_idx_o
);

    logic [DATA_W-1:0] best_q;
    logic [DATA_W-1:0] best_d;
    logic [DATA_W-1:0] second_q;
    logic [DATA_W-1:0] second_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;

    always_comb begin
        best_d   = best_q;
        second_d = second_q;
        idx_d    = idx_q;
        if (clear_i) begin
            best_d   = '0;
            second_d = '0;
            idx_d    = '0;
        end else if (update_i) begin
            if (first_i) begin
                best_d   = logit_i;
                second_d = LOGIT_MIN;
                idx_d    = '0;
            end else if ($signed(logit_i) > $signed(best_q)) begin
                second_d = best_q;
                best_d   = logit_i;
                idx_d    = idx_i;
            end else if ($signed(logit_i) > $signed(second_q)) begin
                second_d = logit_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            best_q   <= '0;
            second_q <= '0;
            idx_q    <= '0;
        end else begin
            best_q   <= best_d;
            second_q <= second_d;
            idx_q    <= idx_d;
        end
    end

    assign best_o     = best_q;
    assign second_o   = second_q;
    assign best_idx_o = idx_q;

endmodule

// File: rtl/dense_logit_argmax_classifier.sv
// Kicks the dense layer, waits for its sticky done, scans the logits and
// publishes the argmax, its logit, the top1-top2 margin and a timeout flag.
module dense_logit_argmax_classifier
    import cnn_accel_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    output logic              up_start_o,
    input  logic              up_done_i,
    output logic [ADDR_W-1:0] up_read_addr_o,
    input  logic [DATA_W-1:0] up_read_data_i,
    output logic [ADDR_W-1:0] class_idx_o,
    output logic [DATA_W-1:0] max_logit_o,
    output logic [DATA_W-1:0] margin_o,
    output logic              busy_o,
    output logic              error_o,
    output logic              done_o,
    output logic [2:0]        dbg_state_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CLASSES - 1);

    argmax_state_t     state_q;
    argmax_state_t     state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              error_q;
    logic              error_d;
    logic              done_q;
    logic              done_d;
    logic [ADDR_W-1:0] class_q;
    logic [ADDR_W-1:0] class_d;
    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] max_d;
    logic [DATA_W-1:0] margin_q;
    logic [DATA_W-1:0] margin_d;

    logic              trk_clear;
    logic              trk_update;
    logic              trk_first;
    logic              up_start;
    logic              busy;
    logic [DATA_W-1:0] trk_best;
    logic [DATA_W-1:0] trk_second;
    logic [ADDR_W-1:0] trk_idx;

    top2_tracker #(
        .ADDR_W(ADDR_W)
    ) u_top2 (
        .clk        (clk),
        .resetn     (resetn),
        .clear_i    (trk_clear),
        .update_i   (trk_update),
        .first_i    (trk_first),
        .logit_i    (up_read_data_i),
        .idx_i      (addr_q),
        .best_o     (trk_best),
        .second_o   (trk_second),
        .best_idx_o (trk_idx)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        error_d    = error_q;
        done_d     = done_q;
        class_d    = class_q;
        max_d      = max_q;
        margin_d   = margin_q;
        trk_clear  = 1'b0;
        trk_update = 1'b0;
        trk_first  = 1'b0;
        up_start   = 1'b0;
        busy       = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start_i) state_d = KICK;
            end
            KICK: begin
                up_start  = 1'b1;
                error_d   = 1'b0;
                cnt_d     = '0;
                addr_d    = '0;
                trk_clear = 1'b1;
                state_d   = WAIT_UP;
            end
            WAIT_UP: begin
                if (up_done_i) begin
                    addr_d  = '0;
                    state_d = SCAN;
                end else if (cnt_q == CNT_LAST) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SCAN: begin
                // Read data for addr_q is valid this cycle; fold it in and step on.
                trk_update = 1'b1;
                trk_first  = (addr_q == '0);
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = FINISH;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            FINISH: begin
                if (error_q) begin
                    class_d  = '0;
                    max_d    = '0;
                    margin_d = '0;
                end else begin
                    class_d  = trk_idx;
                    max_d    = trk_best;
                    margin_d = sat_margin(trk_best, trk_second);
                end
                state_d = DONE;
            end
            DONE: begin
                busy = 1'b0;
                if (start_i) begin
                    done_d  = 1'b0;
                    state_d = KICK;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
            class_q  <= '0;
            max_q    <= '0;
            margin_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            error_q  <= error_d;
            done_q   <= done_d;
            class_q  <= class_d;
            max_q    <= max_d;
            margin_q <= margin_d;
        end
    end

    assign up_start_o     = up_start;
    assign busy_o         = busy;
    assign up_read_addr_o = addr_q;
    assign class_idx_o    = class_q;
    assign max_logit_o    = max_q;
    assign margin_o       = margin_q;
    assign error_o        = error_q;
    assign done_o         = done_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_dense_logit_argmax_classifier.sv
// Bench for dense_logit_argmax_classifier: table vectors, random logits,
// restart, mid-scan reset and a short-timeout instance.
module tb_dense_logit_argmax_classifier;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NCLS   = 9;
    localparam int EXP_W  = ADDR_W + 2 * DATA_W + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic              start = 1'b0;
    logic              up_done = 1'b0;
    logic              up_start;
    logic [ADDR_W-1:0] up_read_addr;
    logic [DATA_W-1:0] up_read_data;
    logic [ADDR_W-1:0] class_idx;
    logic [DATA_W-1:0] max_logit;
    logic [DATA_W-1:0] margin;
    logic              busy;
    logic              error;
    logic              done;
    logic [2:0]        dbg_state;

    logic [DATA_W-1:0] logit_mem [NCLS];

    always_comb begin
        up_read_data = '0;
        if (int'(up_read_addr) < NCLS) up_read_data = logit_mem[int'(up_read_addr)];
    end

    dense_logit_argmax_classifier #(
        .ADDR_W(ADDR_W)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start_i        (start),
        .up_start_o     (up_start),
        .up_done_i      (up_done),
        .up_read_addr_o (up_read_addr),
        .up_read_data_i (up_read_data),
        .class_idx_o    (class_idx),
        .max_logit_o    (max_logit),
        .margin_o       (margin),
        .busy_o         (busy),
        .error_o        (error),
        .done_o         (done),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- short-timeout DUT ----------------
    logic              start_to = 1'b0;
    logic              up_done_to = 1'b0;
    logic [DATA_W-1:0] up_read_data_to = '0;
    logic              up_start_to;
    logic [ADDR_W-1:0] up_read_addr_to;
    logic [ADDR_W-1:0] class_idx_to;
    logic [DATA_W-1:0] max_logit_to;
    logic [DATA_W-1:0] margin_to;
    logic              busy_to;
    logic              error_to;
    logic              done_to;
    logic [2:0]        dbg_state_to;

    dense_logit_argmax_classifier #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (16)
    ) dut_to (
        .clk            (clk),
        .resetn         (resetn),
        .start_i        (start_to),
        .up_start_o     (up_start_to),
        .up_done_i      (up_done_to),
        .up_read_addr_o (up_read_addr_to),
        .up_read_data_i (up_read_data_to),
        .class_idx_o    (class_idx_to),
        .max_logit_o    (max_logit_to),
        .margin_o       (margin_to),
        .busy_o         (busy_to),
        .error_o        (error_to),
        .done_o         (done_to),
        .dbg_state_o    (dbg_state_to)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int n_kick = 0;
    int n_kick_to = 0;
    logic done_prev = 1'b0;
    logic [EXP_W-1:0] exp_q [$];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (up_start) n_kick++;
        if (up_start_to) n_kick_to++;
    end

    // Scoreboard: each rising done retires the oldest expected result.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: done rose with no expected result, class_idx=%0d", class_idx);
            end else begin
                e = exp_q.pop_front();
                check("sb_class_idx", 32'(class_idx), 32'(e[EXP_W-1 -: ADDR_W]));
                check("sb_max_logit", max_logit, e[2*DATA_W : DATA_W+1]);
                check("sb_margin", margin, e[DATA_W:1]);
                check("sb_error", 32'(error), 32'(e[0]));
            end
        end
        done_prev = done;
    end

    // ---------------- reference model ----------------
    function automatic void ref_model(output logic [ADDR_W-1:0] idx, output logic [DATA_W-1:0] mx,
                                      output logic [DATA_W-1:0] mg);
        int bi;
        logic [DATA_W-1:0] s;
        logic [DATA_W:0] d;
        bi = 0;
        for (int k = 1; k < NCLS; k++)
            if ($signed(logit_mem[k]) > $signed(logit_mem[bi])) bi = k;
        s = 32'h8000_0000;
        for (int k = 0; k < NCLS; k++)
            if (k != bi && $signed(logit_mem[k]) > $signed(s)) s = logit_mem[k];
        idx = ADDR_W'(bi);
        mx  = logit_mem[bi];
        d   = {mx[DATA_W-1], mx} - {s[DATA_W-1], s};
        mg  = d[DATA_W] ? 32'hFFFF_FFFF : d[DATA_W-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge: pulses start, releases up_done after 'delay' cycles,
    // then checks done lands 11 edges after the first edge that saw up_done.
    task automatic run_case(input string name, input logic [ADDR_W-1:0] eidx,
                            input logic [DATA_W-1:0] emx, input logic [DATA_W-1:0] emg, input int delay);
        int c;
        int k0;
        up_done = 1'b0;
        exp_q.push_back({eidx, emx, emg, 1'b0});
        k0 = n_kick;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_kick"}, 32'(busy), 32'd1);
        repeat (delay) @(negedge clk);
        up_done = 1'b1;
        c = 0;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
        end
        check({name, "_latency"}, 32'(c), 32'd12);
        check({name, "_kicks"}, 32'(n_kick - k0), 32'd1);
    endtask

    // ---------------- table ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] mx;
        logic [DATA_W-1:0] mg;
        logic [7:0]        delay;
    } vec_t;

    logic [DATA_W-1:0] tbl_lg [4][NCLS];
    vec_t              tbl    [4];

    initial begin : main
        int c;
        int k0;
        logic [ADDR_W-1:0] ridx;
        logic [DATA_W-1:0] rmx;
        logic [DATA_W-1:0] rmg;
        logic [DATA_W-1:0] base;

        tbl_lg[0] = '{32'd5, -32'sd3, 32'd12, 32'd7, 32'd0, -32'sd1, 32'd2, 32'd11, 32'd4};
        tbl[0]    = '{idx: 4'd2, mx: 32'd12, mg: 32'd1, delay: 8'd20};
        tbl_lg[1] = '{-32'sd8, -32'sd8, -32'sd8, -32'sd8, -32'sd8, -32'sd8, -32'sd8, -32'sd8, -32'sd8};
        tbl[1]    = '{idx: 4'd0, mx: 32'hFFFF_FFF8, mg: 32'd0, delay: 8'd3};
        tbl_lg[2] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                      32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        tbl[2]    = '{idx: 4'd0, mx: 32'h7FFF_FFFF, mg: 32'hFFFF_FFFF, delay: 8'd7};
        tbl_lg[3] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd100};
        tbl[3]    = '{idx: 4'd8, mx: 32'd100, mg: 32'd92, delay: 8'd12};

        for (int k = 0; k < NCLS; k++) logit_mem[k] = '0;

        // reset state
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_up_start", 32'(up_start), 32'd0);
        check("rst_class_idx", 32'(class_idx), 32'd0);
        check("rst_max_logit", max_logit, 32'd0);
        check("rst_margin", margin, 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_to_done", 32'(done_to), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // table vectors
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < NCLS; k++) logit_mem[k] = tbl_lg[i][k];
            run_case($sformatf("vec%0d", i), tbl[i].idx, tbl[i].mx, tbl[i].mg, int'(tbl[i].delay));
            repeat (2) @(negedge clk);
        end

        // restart from DONE with up_done still sticky: same logits, same result
        exp_q.push_back({tbl[3].idx, tbl[3].mx, tbl[3].mg, 1'b0});
        k0 = n_kick;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!done && c < 40) begin
            c++;
            @(negedge clk);
        end
        check("restart_done_low_cycles", 32'(c), 32'd13);
        check("restart_kicks", 32'(n_kick - k0), 32'd1);
        repeat (2) @(negedge clk);

        // random logits, some duplicated to exercise ties
        for (int r = 0; r < 3; r++) begin
            base = $urandom;
            for (int k = 0; k < NCLS; k++)
                logit_mem[k] = ($urandom_range(0, 2) == 0) ? base : $urandom;
            ref_model(ridx, rmx, rmg);
            run_case($sformatf("rand%0d", r), ridx, rmx, rmg, $urandom_range(2, 25));
            repeat (2) @(negedge clk);
        end

        // reset in the middle of SCAN
        for (int k = 0; k < NCLS; k++) logit_mem[k] = tbl_lg[0][k];
        up_done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        up_done = 1'b1;
        repeat (4) @(negedge clk);
        check("midscan_state_scan", 32'(dbg_state), 32'd3);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("midrst_state", 32'(dbg_state), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_addr", 32'(up_read_addr), 32'd0);
        check("midrst_class_idx", 32'(class_idx), 32'd0);
        check("midrst_max_logit", max_logit, 32'd0);
        check("midrst_margin", margin, 32'd0);
        @(negedge clk);
        run_case("after_rst", tbl[0].idx, tbl[0].mx, tbl[0].mg, 5);
        repeat (2) @(negedge clk);

        // timeout with TIMEOUT_CYCLES=16; a start during WAIT_UP is ignored
        k0 = n_kick_to;
        start_to = 1'b1;
        @(negedge clk);
        start_to = 1'b0;
        c = 0;
        while (!done_to && c < 60) begin
            c++;
            start_to = (c == 4);
            @(negedge clk);
        end
        start_to = 1'b0;
        check("to_done_low_cycles", 32'(c), 32'd19);
        check("to_done", 32'(done_to), 32'd1);
        check("to_error", 32'(error_to), 32'd1);
        check("to_class_idx", 32'(class_idx_to), 32'd0);
        check("to_max_logit", max_logit_to, 32'd0);
        check("to_margin", margin_to, 32'd0);
        check("to_kicks", 32'(n_kick_to - k0), 32'd1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
